// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- asynchronous serial receiver, 1 start / 8 data (LSB first) /
// 1 stop, no parity.
//
// The raw line goes through a two-flop synchroniser. After that a small FSM
// confirms the start bit at mid-bit and samples every following bit at
// mid-period. A good frame updates dout_o and raises a one-cycle done tick.
// A low stop bit raises a one-cycle framing-error tick instead. The receiver
// then waits for the line to go high again before it looks for a new start.
//
// Parameters
//   c_clkfreq      system clock frequency in Hz
//   c_baudrate     line bit rate; bit_ticks = c_clkfreq / c_baudrate must
//                  lie in 4..65535
//
// Ports
//   clk              system clock, rising edge
//   rst              synchronous, active-high reset
//   rx_i             raw serial line (asynchronous, idle high)
//   dout_o           last correctly received byte, held until the next one
//   rx_done_tick_o   one-cycle pulse when dout_o is updated
//   frame_err_o      one-cycle pulse when the stop bit is sampled low
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int c_clkfreq  = 100_000_000,
    parameter int c_baudrate = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic [7:0] dout_o,
    output logic       rx_done_tick_o,
    output logic       frame_err_o
);

    localparam int c_bit_ticks  = c_clkfreq / c_baudrate;
    localparam int c_half_ticks = c_bit_ticks / 2;

    localparam logic [15:0] c_bit_last  = 16'(c_bit_ticks - 1);
    localparam logic [15:0] c_half_last = 16'(c_half_ticks - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    logic        r_sync1;
    logic        r_sync2;
    logic [2:0]  r_state;
    logic [15:0] r_tick_cnt;
    logic [3:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic [7:0]  r_dout;
    logic        r_done;
    logic        r_ferr;

    logic        w_rx_s;
    logic        w_half_last;
    logic        w_bit_last;

    assign w_rx_s      = r_sync2;
    assign w_half_last = (r_tick_cnt == c_half_last);
    assign w_bit_last  = (r_tick_cnt == c_bit_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_state    <= S_IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_dout     <= '0;
            r_done     <= 1'b0;
            r_ferr     <= 1'b0;
        end else begin
            r_sync1 <= rx_i;
            r_sync2 <= r_sync1;
            // Both ticks are single-cycle; only the stop-bit branch raises one.
            r_done  <= 1'b0;
            r_ferr  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (!w_rx_s) begin
                        r_state    <= S_START;
                        r_tick_cnt <= '0;
                    end
                end

                S_START: begin
                    if (w_half_last) begin
                        r_tick_cnt <= '0;
                        if (!w_rx_s) begin
                            // Still low at mid-start: a real start bit. From
                            // here every sample lands one full bit later.
                            r_state   <= S_DATA;
                            r_bit_cnt <= '0;
                        end else begin
                            // Line returned high: a glitch, drop it silently.
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_tick_cnt <= r_tick_cnt + 16'd1;
                    end
                end

                S_DATA: begin
                    if (w_bit_last) begin
                        r_tick_cnt <= '0;
                        // LSB arrives first, so shift right and insert at MSB.
                        r_shift    <= {w_rx_s, r_shift[7:1]};
                        r_bit_cnt  <= r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'd7) begin
                            r_state <= S_STOP;
                        end
                    end else begin
                        r_tick_cnt <= r_tick_cnt + 16'd1;
                    end
                end

                S_STOP: begin
                    if (w_bit_last) begin
                        r_tick_cnt <= '0;
                        if (w_rx_s) begin
                            // Leaving at mid-stop lets a start bit that
                            // immediately follows a one-bit stop be caught.
                            r_dout  <= r_shift;
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_ferr  <= 1'b1;
                            r_state <= S_BREAK;
                        end
                    end else begin
                        r_tick_cnt <= r_tick_cnt + 16'd1;
                    end
                end

                S_BREAK: begin
                    // A held-low line must not be taken as a stream of starts.
                    if (w_rx_s) begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state    <= S_IDLE;
                    r_tick_cnt <= '0;
                end
            endcase
        end
    end

    assign dout_o         = r_dout;
    assign rx_done_tick_o = r_done;
    assign frame_err_o    = r_ferr;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx -- directed bench for uart_rx.
//
// Two receivers share clock and reset:
//   u_dut_slow : default parameters (868 clocks/bit), used for one frame and
//                the start-edge-to-tick latency.
//   u_dut_fast : 16 clocks/bit, used for back-to-back, glitch, break, reset
//                and the full 0x00..0xFF transmitter-style sweep.
// Frames are driven bit by bit from tasks; a negedge monitor records ticks.
// ---------------------------------------------------------------------------
module tb_uart_rx;

    localparam int c_slow_bit = 868;
    localparam int c_fast_bit = 16;
    localparam int c_fast_frame = 10 * c_fast_bit;

    logic       clk;
    logic       rst;
    logic       rx_slow;
    logic       rx_fast;
    logic [7:0] slow_dout;
    logic       slow_done;
    logic       slow_err;
    logic [7:0] fast_dout;
    logic       fast_done;
    logic       fast_err;

    int tests_run;
    int tests_failed;
    int cyc;

    int slow_done_cnt;
    int slow_err_cnt;
    int slow_last_cyc;
    logic [7:0] slow_last_byte;
    int fast_done_cnt;
    int fast_err_cnt;
    int both_cnt;
    logic [7:0] fast_q[$];
    int fast_tick_cyc[$];

    int start_cyc;

    uart_rx u_dut_slow (
        .clk            (clk),
        .rst            (rst),
        .rx_i           (rx_slow),
        .dout_o         (slow_dout),
        .rx_done_tick_o (slow_done),
        .frame_err_o    (slow_err)
    );

    uart_rx #(
        .c_clkfreq  (1_600_000),
        .c_baudrate (100_000)
    ) u_dut_fast (
        .clk            (clk),
        .rst            (rst),
        .rx_i           (rx_fast),
        .dout_o         (fast_dout),
        .rx_done_tick_o (fast_done),
        .frame_err_o    (fast_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Tick monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (slow_done) begin
            slow_done_cnt++;
            slow_last_cyc  = cyc;
            slow_last_byte = slow_dout;
        end
        if (slow_err) slow_err_cnt++;
        if (fast_done) begin
            fast_done_cnt++;
            fast_q.push_back(fast_dout);
            fast_tick_cyc.push_back(cyc);
        end
        if (fast_err) fast_err_cnt++;
        if ((slow_done && slow_err) || (fast_done && fast_err)) both_cnt++;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic line_set(input bit fast, input logic v);
        if (fast) rx_fast = v;
        else      rx_slow = v;
    endtask

    // Drive level v for n clocks; returns at posedge + 1.
    task automatic hold(input bit fast, input logic v, input int n);
        line_set(fast, v);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input bit fast, input logic [7:0] b, input logic stop_val);
        int bt;
        bt = fast ? c_fast_bit : c_slow_bit;
        $display("[TB] tx 0x%02h stop=%0d line=%s", b, stop_val, fast ? "fast" : "slow");
        start_cyc = cyc;
        hold(fast, 1'b0, bt);
        for (int i = 0; i < 8; i++) hold(fast, b[i], bt);
        hold(fast, stop_val, bt);
    endtask

    initial begin
        int n_done;
        int n_err;
        int lat;
        logic [31:0] got;

        tests_run = 0; tests_failed = 0;
        slow_done_cnt = 0; slow_err_cnt = 0; slow_last_cyc = 0; slow_last_byte = 8'h00;
        fast_done_cnt = 0; fast_err_cnt = 0; both_cnt = 0;
        rx_slow = 1'b1; rx_fast = 1'b1; rst = 1'b1;

        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_fast_dout", fast_dout, 8'h00);
        check_val("rst_fast_done", fast_done, 1'b0);
        check_val("rst_fast_err",  fast_err,  1'b0);
        check_val("rst_slow_dout", slow_dout, 8'h00);

        // Default parameters: 0xA5 and its latency from the start edge.
        send_frame(1'b0, 8'hA5, 1'b1);
        hold(1'b0, 1'b1, 20);
        check_val("slow_done_cnt", slow_done_cnt, 1);
        check_val("slow_byte", slow_last_byte, 8'hA5);
        check_val("slow_dout", slow_dout, 8'hA5);
        check_val("slow_err_cnt", slow_err_cnt, 0);
        // 2 + 434 + 9*868 = 8248, allowed +/-1
        lat = slow_last_cyc - start_cyc;
        $display("[TB] slow latency %0d cycles", lat);
        check_val("slow_latency_in_8247_8249", (lat >= 8247 && lat <= 8249), 1'b1);

        // Back-to-back 0x00, 0xFF, 0x3C.
        fast_q.delete(); fast_tick_cyc.delete();
        send_frame(1'b1, 8'h00, 1'b1);
        send_frame(1'b1, 8'hFF, 1'b1);
        send_frame(1'b1, 8'h3C, 1'b1);
        hold(1'b1, 1'b1, 40);
        check_val("b2b_count", fast_q.size(), 3);
        if (fast_q.size() == 3) begin
            check_val("b2b_byte0", fast_q[0], 8'h00);
            check_val("b2b_byte1", fast_q[1], 8'hFF);
            check_val("b2b_byte2", fast_q[2], 8'h3C);
            check_val("b2b_gap01", fast_tick_cyc[1] - fast_tick_cyc[0], c_fast_frame);
            check_val("b2b_gap12", fast_tick_cyc[2] - fast_tick_cyc[1], c_fast_frame);
        end
        check_val("b2b_err_cnt", fast_err_cnt, 0);

        // Short low glitch (shorter than half a bit) is ignored.
        n_done = fast_done_cnt;
        hold(1'b1, 1'b0, 4);
        hold(1'b1, 1'b1, 40);
        $display("[TB] glitch 4 cycles line=fast");
        check_val("glitch_no_tick", fast_done_cnt, n_done);
        check_val("glitch_no_err", fast_err_cnt, 0);
        check_val("glitch_dout", fast_dout, 8'h3C);
        send_frame(1'b1, 8'h55, 1'b1);
        hold(1'b1, 1'b1, 20);
        check_val("after_glitch_cnt", fast_done_cnt, n_done + 1);
        check_val("after_glitch_dout", fast_dout, 8'h55);

        // Framing error followed by a long break.
        n_done = fast_done_cnt;
        n_err  = fast_err_cnt;
        send_frame(1'b1, 8'h81, 1'b0);
        hold(1'b1, 1'b0, 2000);
        check_val("break_err_once", fast_err_cnt, n_err + 1);
        check_val("break_no_tick", fast_done_cnt, n_done);
        check_val("break_dout_kept", fast_dout, 8'h55);
        hold(1'b1, 1'b1, 40);
        check_val("break_release_err", fast_err_cnt, n_err + 1);
        send_frame(1'b1, 8'h7E, 1'b1);
        hold(1'b1, 1'b1, 20);
        check_val("after_break_dout", fast_dout, 8'h7E);
        check_val("after_break_cnt", fast_done_cnt, n_done + 1);

        // Reset in the middle of data bit 4 of 0xC3. The sender is assumed to
        // be reset as well, so the line returns to idle at the same moment.
        n_done = fast_done_cnt;
        n_err  = fast_err_cnt;
        $display("[TB] tx 0xC3 aborted by reset line=fast");
        hold(1'b1, 1'b0, c_fast_bit);
        for (int i = 0; i < 4; i++) hold(1'b1, (8'hC3 >> i) & 8'h01, c_fast_bit);
        hold(1'b1, 1'b0, c_fast_bit / 2);
        rst = 1'b1;
        rx_fast = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check_val("midrst_dout", fast_dout, 8'h00);
        check_val("midrst_done", fast_done, 1'b0);
        check_val("midrst_err", fast_err, 1'b0);
        hold(1'b1, 1'b1, 200);
        check_val("midrst_no_tick", fast_done_cnt, n_done);
        check_val("midrst_no_err", fast_err_cnt, n_err);
        send_frame(1'b1, 8'h12, 1'b1);
        hold(1'b1, 1'b1, 20);
        check_val("after_rst_dout", fast_dout, 8'h12);

        // Transmitter-style sweep 0x00..0xFF, back to back.
        fast_q.delete(); fast_tick_cyc.delete();
        n_err = fast_err_cnt;
        for (int i = 0; i < 256; i++) send_frame(1'b1, 8'(i), 1'b1);
        hold(1'b1, 1'b1, 40);
        check_val("sweep_count", fast_q.size(), 256);
        for (int i = 0; i < 256; i++) begin
            got = (i < fast_q.size()) ? {24'h0, fast_q[i]} : 32'hFFFF_FFFF;
            check_val($sformatf("sweep_byte_%0d", i), got, i);
        end
        check_val("sweep_err_cnt", fast_err_cnt, n_err);

        check_val("ticks_never_together", both_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
